// File: rtl/neo_io_pkg.sv
// Shared constants and helpers for the NeoGeo I/O block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package neo_io_pkg;

    localparam int NEO_OUTREG_MAX_REG       = 8;
    localparam int NEO_OUTREG_MAX_DW        = 16;
    localparam int NEO_OUTREG_DEF_DW        = 6;
    localparam int NEO_OUTREG_DEF_PULSE_LEN = 16;

    // Width of a down-counter that must hold values 0..len inclusive.
    function automatic int neo_outreg_cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/neo_strobe_sync.sv
// Synchronises the async active-low 68k write strobe and emits one event per falling edge.
// Latency: wr_evt is high in the cycle after the SYNC_STAGES-th edge that samples wr_n low.
// Backpressure: none; a strobe shorter than SYNC_STAGES+1 cycles low or high may be lost.
//
// Ports: clk/rst_n (async active-low), wr_n (raw strobe), wr_evt (single-cycle event).
module neo_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_n,
    output logic wr_evt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Tracks which synchroniser stages hold a real sample rather than the
    // reset preload, so the preloaded '1' cannot arm the edge detector.
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   dly_q, dly_d;
    logic                   armed_q, armed_d;
    logic                   s_last;

    assign s_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], wr_n};
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        dly_d   = s_last;
        // Arm only once the strobe has genuinely been seen high, so a strobe
        // held low across reset release never produces a write.
        armed_d = armed_q | (s_last & vld_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            vld_q   <= '0;
            dly_q   <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            dly_q   <= dly_d;
            armed_q <= armed_d;
        end
    end

    assign wr_evt = armed_q & ~s_last & dly_q;

endmodule

// File: rtl/neo_outreg_bank.sv
// Bank of NREG x DW output latches written by the 68k, optional timed-pulse mode per register.
// Latency: REG_OUT/WR_PULSE update on edge SYNC_STAGES+1 counting the first edge sampling nWR low.
// Backpressure: none; writes to ADDR >= NREG are dropped silently.
//
// Ports: CLK, nRESET (async active-low), CLK_EN (pulse countdown tick), nWR/ADDR/DATA (68k write),
//        PULSE_MASK (static pulse-mode select), REG_OUT (reg i at [i*DW +: DW]),
//        WR_PULSE (one-cycle write flag per reg), BUSY (countdown active per reg).
// Build option: define NEO_OUTREG_PULSE_EN to compile in the pulse counters; otherwise
//        every register is a plain latch, PULSE_MASK/CLK_EN are ignored and BUSY is 0.
module neo_outreg_bank
    import neo_io_pkg::*;
#(
    parameter int NREG        = 4,
    parameter int DW          = NEO_OUTREG_DEF_DW,
    parameter int AW          = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = NEO_OUTREG_DEF_PULSE_LEN
) (
    input  logic               CLK,
    input  logic               nRESET,
    input  logic               CLK_EN,
    input  logic               nWR,
    input  logic [AW-1:0]      ADDR,
    input  logic [DW-1:0]      DATA,
    input  logic [NREG-1:0]    PULSE_MASK,
    output logic [NREG*DW-1:0] REG_OUT,
    output logic [NREG-1:0]    WR_PULSE,
    output logic [NREG-1:0]    BUSY
);

    logic wr_evt;

    neo_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_strobe_sync (
        .clk   (CLK),
        .rst_n (nRESET),
        .wr_n  (nWR),
        .wr_evt(wr_evt)
    );

`ifdef NEO_OUTREG_PULSE_EN
    localparam int CW = neo_outreg_cnt_w(PULSE_LEN);
`else
    logic unused_pulse;
    assign unused_pulse = ^{CLK_EN, PULSE_MASK};
    assign BUSY         = '0;
`endif

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        logic          hit;
        logic [DW-1:0] reg_q, reg_d;
        logic          wr_pulse_q, wr_pulse_d;

        // Out-of-range addresses match no register, so they are ignored here.
        assign hit = wr_evt && (ADDR == AW'(i));

`ifdef NEO_OUTREG_PULSE_EN
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            reg_d      = reg_q;
            cnt_d      = cnt_q;
            wr_pulse_d = 1'b0;
            if (hit) begin
                // A write always beats a coincident tick; nonzero data (re)starts
                // the full pulse, zero data clears register and counter at once.
                reg_d      = DATA;
                wr_pulse_d = 1'b1;
                cnt_d      = (PULSE_MASK[i] && (DATA != '0)) ? CW'(PULSE_LEN) : '0;
            end else if (!PULSE_MASK[i]) begin
                cnt_d = '0;
            end else if (CLK_EN && (cnt_q != '0)) begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    reg_d = '0;
                end
            end
        end

        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET) begin
                reg_q      <= '0;
                cnt_q      <= '0;
                wr_pulse_q <= 1'b0;
            end else begin
                reg_q      <= reg_d;
                cnt_q      <= cnt_d;
                wr_pulse_q <= wr_pulse_d;
            end
        end

        assign BUSY[i] = (cnt_q != '0);
`else
        always_comb begin
            reg_d      = reg_q;
            wr_pulse_d = 1'b0;
            if (hit) begin
                reg_d      = DATA;
                wr_pulse_d = 1'b1;
            end
        end

        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET) begin
                reg_q      <= '0;
                wr_pulse_q <= 1'b0;
            end else begin
                reg_q      <= reg_d;
                wr_pulse_q <= wr_pulse_d;
            end
        end
`endif

        assign REG_OUT[i*DW +: DW] = reg_q;
        assign WR_PULSE[i]         = wr_pulse_q;
    end

endmodule

// File: tb/tb_neo_outreg_bank.sv
// Bench for neo_outreg_bank: a 4-register and a 3-register instance share one stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_neo_outreg_bank;

    localparam int DW   = 6;
    localparam int PLEN = 4;
    localparam int SYNC = 2;
`ifdef NEO_OUTREG_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset;
    logic        clk_en;
    logic        n_wr;
    logic [1:0]  addr;
    logic [5:0]  data;
    logic [3:0]  pmask;
    logic [23:0] reg_out4;
    logic [3:0]  wr4, busy4;
    logic [17:0] reg_out3;
    logic [2:0]  wr3, busy3;

    always #5 clk = ~clk;

    neo_outreg_bank #(.NREG(4), .DW(DW), .SYNC_STAGES(SYNC), .PULSE_LEN(PLEN)) u_dut4 (
        .CLK(clk), .nRESET(n_reset), .CLK_EN(clk_en), .nWR(n_wr), .ADDR(addr), .DATA(data),
        .PULSE_MASK(pmask), .REG_OUT(reg_out4), .WR_PULSE(wr4), .BUSY(busy4));

    neo_outreg_bank #(.NREG(3), .DW(DW), .SYNC_STAGES(SYNC), .PULSE_LEN(PLEN)) u_dut3 (
        .CLK(clk), .nRESET(n_reset), .CLK_EN(clk_en), .nWR(n_wr), .ADDR(addr), .DATA(data),
        .PULSE_MASK(pmask[2:0]), .REG_OUT(reg_out3), .WR_PULSE(wr3), .BUSY(busy3));

    // Reference model: register values, remaining pulse ticks and write flags per instance.
    int m_reg [2][4];
    int m_cnt [2][4];
    bit m_wr  [2][4];
    int ecnt, due;
    bit prev_s, seen_high;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int en_mode  = 0;     // 0: hold clk_en, 1: toggle each cycle, 2: random
    int ticks0, clear_ticks, clear_cnt, wr_count4;

    typedef struct {
        logic [1:0]  addr;
        logic [5:0]  data;
        logic [23:0] exp4;
        logic [3:0]  expw4;
        logic [17:0] exp3;
        logic [2:0]  expw3;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                m_reg[d][i] = 0; m_cnt[d][i] = 0; m_wr[d][i] = 0;
            end
        ecnt = 0; due = -1; prev_s = 1'b1; seen_high = 1'b0;
    endtask

    // One rising edge: a write lands SYNC edges after the first low sample of a
    // falling strobe, provided the strobe was seen high after reset beforehand.
    task automatic model_edge();
        bit commit;
        if (!n_reset) begin
            model_reset();
            return;
        end
        ecnt++;
        commit = (due == ecnt);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                int nreg;
                nreg = (d == 0) ? 4 : 3;
                m_wr[d][i] = 0;
                if (i < nreg) begin
                    if (commit && int'(addr) == i) begin
                        m_reg[d][i] = int'(data);
                        m_wr[d][i]  = 1;
                        m_cnt[d][i] = (PULSE_EN && pmask[i] && data != 0) ? PLEN : 0;
                    end else if (PULSE_EN && pmask[i] && clk_en && m_cnt[d][i] > 0) begin
                        m_cnt[d][i]--;
                        if (m_cnt[d][i] == 0) m_reg[d][i] = 0;
                    end
                end
            end
        end
        if (!n_wr && prev_s && seen_high) due = ecnt + SYNC;
        seen_high = seen_high | n_wr;
        prev_s    = n_wr;
    endtask

    task automatic cyc();
        logic [23:0] e4;
        logic [17:0] e3;
        logic [3:0]  w4, b4;
        logic [2:0]  w3, b3;
        logic [5:0]  prev0;
        bit          en_edge;
        if (en_mode == 1) clk_en = ~clk_en;
        else if (en_mode == 2) clk_en = 1'($urandom_range(0, 1));
        prev0 = reg_out4[5:0];
        @(posedge clk);
        en_edge = clk_en;
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            e4[i*6 +: 6] = 6'(m_reg[0][i]);
            w4[i] = m_wr[0][i];
            b4[i] = (m_cnt[0][i] != 0);
        end
        for (int i = 0; i < 3; i++) begin
            e3[i*6 +: 6] = 6'(m_reg[1][i]);
            w3[i] = m_wr[1][i];
            b3[i] = (m_cnt[1][i] != 0);
        end
        check("model_reg_out4", 32'(reg_out4), 32'(e4));
        check("model_wr_pulse4", 32'(wr4), 32'(w4));
        check("model_busy4", 32'(busy4), 32'(b4));
        check("model_reg_out3", 32'(reg_out3), 32'(e3));
        check("model_wr_pulse3", 32'(wr3), 32'(w3));
        check("model_busy3", 32'(busy3), 32'(b3));
        // Pulse-length monitor for register 0 of the 4-register instance.
        if (|wr4) wr_count4++;
        if (wr4[0]) ticks0 = 0;
        else if (en_edge) ticks0++;
        if (prev0 != 0 && reg_out4[5:0] == 0 && !wr4[0]) begin
            clear_ticks = ticks0;
            clear_cnt++;
        end
    endtask

    task automatic do_reset(input logic [3:0] mask, input logic rel_nwr);
        n_reset = 1'b0;
        model_reset();
        pmask = mask;
        for (int k = 0; k < 4; k++) begin
            n_wr   = 1'($urandom_range(0, 1));
            addr   = 2'($urandom);
            data   = 6'($urandom);
            clk_en = 1'($urandom_range(0, 1));
            cyc();
            check("rst_reg_out", 32'(reg_out4), 32'd0);
            check("rst_wr_pulse", 32'(wr4), 32'd0);
            check("rst_busy", 32'(busy4), 32'd0);
        end
        n_wr    = rel_nwr;
        clk_en  = 1'b0;
        n_reset = 1'b1;
    endtask

    task automatic strobe(input logic [1:0] a, input logic [5:0] dv, input int lo, input int hi);
        addr = a;
        data = dv;
        n_wr = 1'b0;
        repeat (lo) cyc();
        n_wr = 1'b1;
        repeat (hi) cyc();
    endtask

    initial begin
        int          want_ticks, want_clears;
        logic [23:0] prev4;
        n_reset = 1'b0; n_wr = 1'b1; clk_en = 1'b0; addr = '0; data = '0; pmask = '0;
        ticks0 = 0; clear_ticks = -1; clear_cnt = 0; wr_count4 = 0;
        want_ticks  = PULSE_EN ? PLEN : -1;
        want_clears = PULSE_EN ? 1 : 0;
        tbl[0] = '{2'd1, 6'h2A, 24'h000A80, 4'b0010, 18'h00A80, 3'b010};
        tbl[1] = '{2'd3, 6'h15, 24'h540A80, 4'b1000, 18'h00A80, 3'b000};
        tbl[2] = '{2'd0, 6'h3F, 24'h540ABF, 4'b0001, 18'h00ABF, 3'b001};
        tbl[3] = '{2'd2, 6'h01, 24'h541ABF, 4'b0100, 18'h01ABF, 3'b100};
        tbl[4] = '{2'd1, 6'h00, 24'h54103F, 4'b0010, 18'h0103F, 3'b010};
        model_reset();

        // Plain writes from the vector table, one full strobe each.
        do_reset(4'b0000, 1'b1);
        en_mode = 0;
        repeat (3) cyc();
        prev4 = '0;
        for (int v = 0; v < 5; v++) begin
            addr = tbl[v].addr; data = tbl[v].data; n_wr = 1'b0;
            cyc(); cyc();
            check("tbl_early_wr", 32'(wr4), 32'd0);
            check("tbl_early_reg", 32'(reg_out4), 32'(prev4));
            cyc();
            check("tbl_reg_out4", 32'(reg_out4), 32'(tbl[v].exp4));
            check("tbl_wr4", 32'(wr4), 32'(tbl[v].expw4));
            check("tbl_reg_out3", 32'(reg_out3), 32'(tbl[v].exp3));
            check("tbl_wr3", 32'(wr3), 32'(tbl[v].expw3));
            cyc(); cyc();
            check("tbl_no_repeat_wr", 32'(wr4), 32'd0);
            check("tbl_hold_reg", 32'(reg_out4), 32'(tbl[v].exp4));
            n_wr = 1'b1;
            repeat (4) cyc();
            prev4 = tbl[v].exp4;
        end

        // Pulse mode on register 0, CLK_EN every second cycle.
        do_reset(4'b0001, 1'b1);
        en_mode = 1;
        repeat (3) cyc();
        clear_ticks = -1; clear_cnt = 0;
        strobe(2'd0, 6'd3, 4, 3);
        repeat (16) cyc();
        check("pulse_ticks", 32'(clear_ticks), 32'(want_ticks));
        check("pulse_clears", 32'(clear_cnt), 32'(want_clears));
        check("pulse_reg_after", 32'(reg_out4[5:0]), PULSE_EN ? 32'd0 : 32'd3);
        check("pulse_busy_after", 32'(busy4), 32'd0);

        // Retrigger before expiry extends the pulse from the latest write.
        clear_ticks = -1; clear_cnt = 0;
        strobe(2'd0, 6'd3, 3, 3);
        strobe(2'd0, 6'd5, 3, 3);
        repeat (16) cyc();
        check("retrig_ticks", 32'(clear_ticks), 32'(want_ticks));
        check("retrig_clears", 32'(clear_cnt), 32'(want_clears));
        check("retrig_reg_after", 32'(reg_out4[5:0]), PULSE_EN ? 32'd0 : 32'd5);

        // Zero write during an active pulse clears at once.
        strobe(2'd0, 6'd3, 3, 3);
        addr = 2'd0; data = 6'd0; n_wr = 1'b0;
        repeat (3) cyc();
        check("zero_wr_pulse", 32'(wr4[0]), 32'd1);
        check("zero_wr_reg", 32'(reg_out4[5:0]), 32'd0);
        check("zero_wr_busy", 32'(busy4[0]), 32'd0);
        n_wr = 1'b1;
        repeat (3) cyc();

        // Asynchronous reset in the middle of a pulse.
        addr = 2'd0; data = 6'd3; n_wr = 1'b0;
        repeat (3) cyc();
        n_wr = 1'b1;
        for (int k = 0; k < 20 && ticks0 < 2; k++) cyc();
        check("mid_wait_ticks", 32'(ticks0), 32'd2);
        check("mid_busy", 32'(busy4[0]), 32'(PULSE_EN));
        n_reset = 1'b0;
        #1;
        check("async_rst_reg", 32'(reg_out4), 32'd0);
        check("async_rst_busy", 32'(busy4), 32'd0);
        check("async_rst_reg3", 32'(reg_out3), 32'd0);
        model_reset();
        cyc(); cyc();
        n_reset = 1'b1;
        repeat (2) cyc();

        // nWR held low across reset release must not write.
        en_mode = 0;
        do_reset(4'b0000, 1'b0);
        wr_count4 = 0;
        repeat (10) cyc();
        check("held_low_no_wr", 32'(wr_count4), 32'd0);
        n_wr = 1'b1;
        repeat (3) cyc();
        addr = 2'd2; data = 6'h11; n_wr = 1'b0;
        repeat (6) cyc();
        check("rearm_one_wr", 32'(wr_count4), 32'd1);
        check("rearm_reg2", 32'(reg_out4[17:12]), 32'h11);
        n_wr = 1'b1;
        repeat (3) cyc();

        // Randomised strobes against the model.
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(4'($urandom), 1'b1);
            en_mode = 2;
            repeat (3) cyc();
            for (int s = 0; s < 40; s++) begin
                strobe(2'($urandom),
                       ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom),
                       int'($urandom_range(3, 6)), int'($urandom_range(3, 6)));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
